// File: rtl/pixel_requantizer_if.sv
// Pixel beat stream: N packed lanes plus line/frame framing.
// The master drives every field; the slave only consumes the input framing.
interface pixel_requantizer_if #(
   parameter int W = 40
);
   logic [W-1:0] data;
   logic         valid;
   logic         eol;
   logic         eof;
   logic         sof;

   modport master (
      output data, valid, eol, eof, sof
   );
   modport slave (
      input data, valid, eol, eof
   );
endinterface

// File: rtl/pixel_requantizer.sv
// Multi-lane pixel requantizer with SOF/geometry tracking and frame timestamp.
// Define PIXEL_REQUANTIZER_DITHER_EN to replace the mode-1 rounding constant with LFSR dither.
module pixel_requantizer #(
   parameter int DATA_BITS  = 40,
   parameter int PIXEL_BITS = 10,
   parameter int OUT_BITS   = 8,
   parameter int SHIFT_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   pixel_requantizer_if.slave    s_px,
   pixel_requantizer_if.master   m_px,
   input  logic [1:0]            cfg_mode,
   input  logic [SHIFT_BITS-1:0] cfg_shift,
   input  logic [15:0]           cfg_hbeats,
   input  logic [15:0]           cfg_vlines,
   input  logic [31:0]           time_abs,
   input  logic                  err_clear,
   output logic [31:0]           frame_ts,
   output logic                  ts_valid,
   output logic                  err_hsize,
   output logic                  err_vsize,
   output logic [15:0]           frame_count
);
   localparam int N  = DATA_BITS / PIXEL_BITS;
   localparam int D  = PIXEL_BITS - OUT_BITS;
   localparam int OW = N * OUT_BITS;

   typedef enum logic {IDLE, IN_FRAME} state_t;

   state_t                state, state_nxt;
   logic                  sof;
   logic [1:0]            sh_mode, eff_mode;
   logic [SHIFT_BITS-1:0] sh_shift, eff_shift;
   logic [15:0]           beat_cnt, line_cnt;
   logic                  h_bad, v_bad;
   logic [D-1:0]          rnd;
   logic [OW-1:0]         s1_data_d, s1_data;
   logic                  s1_valid, s1_eol, s1_eof, s1_sof;
   logic                  s1_hbad, s1_vbad;
   logic [31:0]           s1_ts;

   function automatic logic [OUT_BITS-1:0] requant(
      input logic [PIXEL_BITS-1:0] p,
      input logic [1:0]            mode,
      input logic [SHIFT_BITS-1:0] sh,
      input logic [D-1:0]          r
   );
      logic [PIXEL_BITS:0]   sum;
      logic [PIXEL_BITS-1:0] win;
      logic [OUT_BITS-1:0]   q;
      sum = {1'b0, p} + {{(OUT_BITS + 1){1'b0}}, r};
      win = p >> sh;
      unique case (1'b1)
         (mode == 2'd1):
            q = sum[PIXEL_BITS] ? '1 : sum[PIXEL_BITS-1:D];
         (mode == 2'd2):
            q = (|win[PIXEL_BITS-1:OUT_BITS]) ? '1 : win[OUT_BITS-1:0];
         default:
            q = p[PIXEL_BITS-1:D];
      endcase
      return q;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Beats outside a frame use the live config; inside, the value latched at SOF.
   always_comb begin
      state_nxt = state;
      sof       = 1'b0;
      eff_mode  = sh_mode;
      eff_shift = sh_shift;
      unique case (state)
         IDLE: begin
            eff_mode  = cfg_mode;
            eff_shift = cfg_shift;
            if (s_px.valid) begin
               sof = 1'b1;
               if (!s_px.eof) state_nxt = IN_FRAME;
            end
         end
         IN_FRAME: begin
            if (s_px.valid && s_px.eof) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_mode  <= 2'd0;
         sh_shift <= '0;
      end else if (state == IDLE) begin
         sh_mode  <= cfg_mode;
         sh_shift <= cfg_shift;
      end
   end

`ifdef PIXEL_REQUANTIZER_DITHER_EN
   logic [15:0] lfsr;
   logic [31:0] rot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lfsr <= 16'hACE1;
      else if (s_px.valid)
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   // Each lane taps a different rotation so neighbours do not dither in lockstep.
   always_comb begin
      s1_data_d = '0;
      rnd       = '0;
      rot       = '0;
      for (int i = 0; i < N; i++) begin
         rot = {lfsr, lfsr} >> ((i * 5) % 16);
         rnd = rot[D-1:0];
         s1_data_d[i*OUT_BITS +: OUT_BITS] =
            requant(s_px.data[i*PIXEL_BITS +: PIXEL_BITS],
                    eff_mode, eff_shift, rnd);
      end
   end
`else
   localparam logic [D-1:0] HALF = D'(1 << (D - 1));

   always_comb begin
      s1_data_d = '0;
      rnd       = HALF;
      for (int i = 0; i < N; i++) begin
         s1_data_d[i*OUT_BITS +: OUT_BITS] =
            requant(s_px.data[i*PIXEL_BITS +: PIXEL_BITS],
                    eff_mode, eff_shift, rnd);
      end
   end
`endif

   always_comb begin
      h_bad = s_px.valid && (s_px.eol || s_px.eof) &&
              (cfg_hbeats != 16'd0) &&
              (beat_cnt + 16'd1 != cfg_hbeats);
      v_bad = s_px.valid && s_px.eof &&
              (cfg_vlines != 16'd0) &&
              (line_cnt + 16'd1 != cfg_vlines);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt <= 16'd0;
         line_cnt <= 16'd0;
      end else if (s_px.valid) begin
         if (s_px.eol || s_px.eof) beat_cnt <= 16'd0;
         else                      beat_cnt <= beat_cnt + 16'd1;
         if (s_px.eof)      line_cnt <= 16'd0;
         else if (s_px.eol) line_cnt <= line_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_data  <= '0;
         s1_valid <= 1'b0;
         s1_eol   <= 1'b0;
         s1_eof   <= 1'b0;
         s1_sof   <= 1'b0;
         s1_hbad  <= 1'b0;
         s1_vbad  <= 1'b0;
         s1_ts    <= 32'd0;
      end else begin
         s1_data  <= s1_data_d;
         s1_valid <= s_px.valid;
         s1_eol   <= s_px.valid & s_px.eol;
         s1_eof   <= s_px.valid & s_px.eof;
         s1_sof   <= sof;
         s1_hbad  <= h_bad;
         s1_vbad  <= v_bad;
         if (sof) s1_ts <= time_abs;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_px.data   <= '0;
         m_px.valid  <= 1'b0;
         m_px.eol    <= 1'b0;
         m_px.eof    <= 1'b0;
         m_px.sof    <= 1'b0;
         ts_valid    <= 1'b0;
         frame_ts    <= 32'd0;
         err_hsize   <= 1'b0;
         err_vsize   <= 1'b0;
         frame_count <= 16'd0;
      end else begin
         m_px.data  <= s1_data;
         m_px.valid <= s1_valid;
         m_px.eol   <= s1_eol;
         m_px.eof   <= s1_eof;
         m_px.sof   <= s1_sof;
         ts_valid   <= s1_sof;
         if (s1_sof) frame_ts <= s1_ts;
         // A fresh error outranks a clear landing on the same cycle.
         if (s1_hbad)        err_hsize <= 1'b1;
         else if (err_clear) err_hsize <= 1'b0;
         if (s1_vbad)        err_vsize <= 1'b1;
         else if (err_clear) err_vsize <= 1'b0;
         if (s1_eof) frame_count <= frame_count + 16'd1;
      end
   end
endmodule

// File: doc/pixel_requantizer.md
Name: pixel_requantizer

Overview:
Parametrised multi-lane pixel bit-depth reducer that sits between column-level correction and the detection/tag stages. It converts N lanes of PIXEL_BITS pixels to OUT_BITS using a frame-synchronous, software-selected mode (truncate, round-saturate, shifted window). It also generates SOF, checks frame geometry, counts frames, and captures a per-frame timestamp aligned to the output stream.

Parameters:
DATA_BITS, 40, input beat width; N = DATA_BITS/PIXEL_BITS lanes
PIXEL_BITS, 10, input pixel width
OUT_BITS, 8, output pixel width; must satisfy 1 <= OUT_BITS < PIXEL_BITS
SHIFT_BITS, 4, width of cfg_shift

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
data_i  in  DATA_BITS  N pixels, lane 0 in LSBs
valid_i  in  1  beat valid
eol_i  in  1  last beat of line (qualified by valid_i)
eof_i  in  1  last beat of frame (qualified by valid_i)
cfg_mode  in  2  0 truncate, 1 round, 2 window, 3 reserved (behaves as 0)
cfg_shift  in  SHIFT_BITS  right shift for mode 2
cfg_hbeats  in  16  expected beats per line; 0 disables check
cfg_vlines  in  16  expected lines per frame; 0 disables check
time_abs  in  32  free-running time
err_clear  in  1  clears sticky errors
data_o  out  N*OUT_BITS  requantized pixels
valid_o, eol_o, eof_o  out  1 each  delayed controls
sof_o  out  1  first output beat of frame
frame_ts  out  32  time_abs sampled on input SOF beat
ts_valid  out  1  one-cycle pulse, coincident with sof_o
err_hsize  out  1  sticky line-length mismatch
err_vsize  out  1  sticky line-count mismatch
frame_count  out  16  completed frames, wraps at 0xFFFF->0

Behaviour:
- Reset: clk/rst as stated; all outputs 0; state IDLE; shadow cfg = mode 0, shift 0; counters 0.
- Fixed latency of 2 clk from data_i/valid_i to data_o/valid_o. Stage 1: lane arithmetic and control registration. Stage 2: output registers. No backpressure. Bubbles (valid_i=0) are preserved. eol_o, eof_o and sof_o are asserted only when valid_o=1.
- FSM IDLE/IN_FRAME:
  - IDLE: shadow cfg (mode, shift) is loaded from the ports every cycle. A valid beat is SOF and uses the port cfg directly. It moves to IN_FRAME unless eof_i is also set (single-beat frame stays IDLE).
  - IN_FRAME: shadow cfg is frozen. valid_i && eof_i returns to IDLE.
  - Reset mid-frame: the next valid beat is SOF.
- Lane math, D = PIXEL_BITS-OUT_BITS, p = lane input:
  - Mode 0: p[PIXEL_BITS-1:D].
  - Mode 1: (p + 2^(D-1)) >> D, computed at PIXEL_BITS+1 width; saturates to all-ones on overflow.
  - Mode 2: p >> cfg_shift; saturates to all-ones if the result exceeds 2^OUT_BITS-1.
- Geometry:
  - beat_cnt increments on each valid beat and clears after eol or eof.
  - On a valid eol or eof beat: if cfg_hbeats != 0 and beat_cnt+1 != cfg_hbeats, set err_hsize.
  - eof implies end of line. line_cnt increments on eol or eof.
  - On eof: if cfg_vlines != 0 and line_cnt+1 != cfg_vlines, set err_vsize; line_cnt clears.
  - Errors are visible 2 cycles after the offending beat.
  - err_clear clears both errors. A simultaneous set wins over clear.
- frame_count increments on the cycle eof_o is output.
- Timestamp: time_abs is captured on the input SOF beat and pipelined. frame_ts updates and ts_valid pulses on the same cycle as sof_o. frame_ts holds until the next SOF.

Optional Feature:
PIXEL_REQUANTIZER_DITHER_EN
- Defined: mode 1 replaces the constant 2^(D-1) with D bits from a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed 0xACE1 on rst). The LFSR advances on each valid beat, and each lane uses a distinct rotation of the state. Saturation is unchanged.
- Undefined: no LFSR is present; mode 1 is deterministic round-half-up.

Test Plan:
1. N=4, 10->8, mode 1, lanes {0x3FF,0x202,0x201,0x001} -> data_o lanes {0xFF,0x81,0x80,0x00}, valid_o exactly 2 cycles later.
2. Mode 0, lanes {0x3FF,0x203,0x004,0x003} -> {0xFF,0x80,0x01,0x00}. Mode 2 shift=1, {0x0F0,0x200,0x1FE,0x000} -> {0x78,0xFF,0xFF,0x00}.
3. Mode switched 0->1 after the 3rd beat of a frame -> the rest of that frame is truncated; the next frame is rounded from its SOF beat.
4. cfg_hbeats=4, line of 5 beats -> err_hsize=1 2 cycles after eol beat. err_clear -> 0. Then cfg_vlines=2 with a 3-line frame -> err_vsize=1.
5. time_abs=0x00001234 on SOF beat, then 0x5678 on later beats -> frame_ts=0x1234 with ts_valid=sof_o=1 2 cycles later; frame_count goes 0->1 on eof_o.
6. Assert rst mid-frame, release, send 2-beat frame -> all outputs 0 during reset; first post-reset beat yields sof_o=1; no spurious errors with geometry checks set to 0.
